hedios_slot_monitor: RTL
========================

Name: hedios_slot_monitor

Overview:
- Event-counter bank that sits directly upstream of the endpoint and drives its `hedios_slots` input.
- Counts rising edges on SLOT_COUNT asynchronous event lines into live 32-bit counters.
- Publishes frozen snapshots to the slot outputs when the controller fires a snapshot action.
- Each snapshot also carries a cycle timestamp so the host can read consistent, rate-computable values.

Parameters:
- SLOT_COUNT, 4, number of event channels / slot outputs (1..32)
- SYNC_STAGES, 2, synchronizer flops per event input (>=2)
- SATURATE, 1, 1 = counters stick at 0xFFFFFFFF; 0 = wrap to 0

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset
- event_in  input  SLOT_COUNT  asynchronous event lines; one count per rising edge
- snapshot  input  1  one-cycle pulse, from a `hedios_actions` bit
- clear  input  1  one-cycle pulse, from a `hedios_actions` bit
- action_argument  input  32  qualifies snapshot; bit0 = clear_after_snapshot
- enable  input  1  counting gate; 0 holds live counters
- hedios_slots  output  [SLOT_COUNT-1:0][31:0]  snapshot registers
- snapshot_time  output  32  free-running cycle count latched at snapshot
- snapshot_count  output  16  number of snapshots taken, wraps
- overflow  output  SLOT_COUNT  sticky per-channel saturation/wrap flag

Behaviour:
- Reset (rst==0 at a clk edge):
  - Clears all live counters, `hedios_slots`, `snapshot_time`, `snapshot_count`, `overflow`, the cycle counter, synchronizer flops and edge-detect flops.
  - Reset overrides snapshot and clear in the same cycle.
  - A reset mid-count discards all history.
- Synchronization:
  - `event_in[i]` passes through a chain of SYNC_STAGES flops, then one previous-value flop.
  - rise[i] = sync_out & ~prev.
  - A level first sampled at edge t is counted at edge t+SYNC_STAGES. With default 2, the live counter changes 2 edges after first capture.
- Pulse width: events shorter than one clk period may be missed. Edges closer than 2 clk periods apart are not guaranteed distinct counts. Both are documented limits, not errors.
- Counting (enable==1, rise[i]==1):
  - live[i] <= live[i]+1.
  - At 0xFFFFFFFF: SATURATE=1 holds the value; SATURATE=0 goes to 0. In both cases set overflow[i].
  - enable==0: rises are dropped, not deferred. Synchronizer and edge detect keep running, so re-enabling mid-high does not produce a spurious count.
- Cycle counter: 32-bit, increments every cycle out of reset, wraps, never saturates.
- Snapshot (snapshot==1):
  - `hedios_slots[i]` <= live[i] as it was before this edge's increment; a rise in the same cycle goes to live only.
  - `snapshot_time` <= cycle counter pre-increment value.
  - `snapshot_count` <= `snapshot_count`+1.
  - Outputs update the edge after the pulse (latency 1) and are stable until the next snapshot.
- clear_after_snapshot (snapshot==1 && action_argument[0]==1):
  - Live counters <= 0, or 1 if rise[i] that cycle.
  - `overflow` is not cleared.
- Clear (clear==1):
  - Live counters <= rise[i]&enable ? 1 : 0.
  - overflow <= 0.
  - Slot outputs, `snapshot_time` and `snapshot_count` are unchanged.
- Simultaneous snapshot and clear: the snapshot captures the pre-clear values, then the clear is applied in the same edge. `overflow` is cleared.
- Every path is a single-cycle register update; there is no FSM busy state. snapshot and clear may be asserted back-to-back every cycle.

Decomposition:
- Package hedios_monitor_pkg:
  - SLOT_W=32, TS_W=32, SNAPCNT_W=16
  - ARG_CLEAR_AFTER_SNAP=0 (bit index)
  - counter max constant
- Sub-module hedios_edge_sync:
  - Parameter SYNC_STAGES; one instance per channel in a generate loop.
  - Ports clk, rst, async_in, rise_pulse.
  - Contains the sync chain and edge detect.

Test Plan:
- Reset, then 5 clean rising edges on event_in[1] (each 4 cycles high, 4 cycles low), then a snapshot pulse → hedios_slots[1]=5, other slots 0, snapshot_count=1, overflow=0.
- Snapshot pulse at cycle 100 after reset deassert → snapshot_time=100 one edge later; a second snapshot at cycle 150 → snapshot_time=150, snapshot_count=2.
- Rise on event_in[0] counted in the same cycle as snapshot with action_argument=1, live=7 → slot[0]=7; a later snapshot with no further events reads 1.
- SATURATE=1: force live[2]=0xFFFFFFFE, apply 3 edges → snapshot reads 0xFFFFFFFF, overflow[2]=1; a clear pulse → overflow=0, next snapshot reads 0. With SATURATE=0 the same stimulus reads 1.
- enable=0 while 4 edges arrive on event_in[3], then raise enable while the line is still high → no count; next snapshot slot[3]=0.
- rst driven low for one edge mid-count (live=9) while snapshot=1 → all outputs 0, snapshot ignored, snapshot_count=0.

Source files
------------

// File: rtl/hedios_monitor_pkg.sv
// Shared widths and constants for the hedios slot monitor.
// Latency: n/a. Backpressure: n/a.
package hedios_monitor_pkg;

  localparam int SLOT_W    = 32;
  localparam int TS_W      = 32;
  localparam int SNAPCNT_W = 16;

  // Bit of action_argument that requests a live-counter clear after a snapshot
  localparam int ARG_CLEAR_AFTER_SNAP = 0;

  localparam logic [SLOT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/hedios_edge_sync.sv
// Synchronizes one asynchronous event line and emits a one-cycle pulse per rising edge.
// Latency: a level first sampled at edge t pulses during the cycle before edge t+SYNC_STAGES.
// Backpressure: none; pulses closer than two clocks apart may merge.
module hedios_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/hedios_slot_monitor.sv
// Per-channel event counters with snapshot publication to hedios_slots plus timestamp.
// Latency: snapshot/clear take effect at the edge after the pulse; counts land SYNC_STAGES edges after capture.
// Backpressure: none; snapshot and clear may be pulsed every cycle.
module hedios_slot_monitor
  import hedios_monitor_pkg::*;
#(
  parameter int SLOT_COUNT  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int SATURATE    = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [SLOT_COUNT-1:0]               event_in,
  input  logic                                snapshot,
  input  logic                                clear,
  input  logic [31:0]                         action_argument,
  input  logic                                enable,
  output logic [SLOT_COUNT-1:0][SLOT_W-1:0]   hedios_slots,
  output logic [TS_W-1:0]                     snapshot_time,
  output logic [SNAPCNT_W-1:0]                snapshot_count,
  output logic [SLOT_COUNT-1:0]               overflow
);

  logic [SLOT_COUNT-1:0]             rise;
  logic [SLOT_COUNT-1:0]             cnt_en;
  logic [SLOT_COUNT-1:0][SLOT_W-1:0] live;
  logic [TS_W-1:0]                   cycle_cnt;
  logic                              clr_live;
  logic                              unused_arg;

  for (genvar i = 0; i < SLOT_COUNT; i++) begin : g_sync
    hedios_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk       (clk),
      .rst       (rst),
      .async_in  (event_in[i]),
      .rise_pulse(rise[i])
    );
  end

  // Rises seen while disabled are dropped, never deferred
  assign cnt_en     = rise & {SLOT_COUNT{enable}};
  assign clr_live   = clear | (snapshot & action_argument[ARG_CLEAR_AFTER_SNAP]);
  assign unused_arg = ^action_argument[31:1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      live           <= '0;
      hedios_slots   <= '0;
      snapshot_time  <= '0;
      snapshot_count <= '0;
      overflow       <= '0;
      cycle_cnt      <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (snapshot) begin
        hedios_slots   <= live;
        snapshot_time  <= cycle_cnt;
        snapshot_count <= snapshot_count + 1'b1;
      end
      for (int i = 0; i < SLOT_COUNT; i++) begin
        if (clr_live) begin
          live[i] <= {{(SLOT_W-1){1'b0}}, cnt_en[i]};
        end else if (cnt_en[i]) begin
          if (live[i] == CNT_MAX) begin
            live[i]     <= (SATURATE != 0) ? CNT_MAX : '0;
            overflow[i] <= 1'b1;
          end else begin
            live[i] <= live[i] + 1'b1;
          end
        end
      end
      // Clear wins over any overflow raised at the same edge
      if (clear) overflow <= '0;
    end
  end

endmodule
